axis_framer: RTL and testbench
==============================

AXIS_FRAMER -- requirements
Module: axis_framer

Interface
REQ-001 SHALL have parameter FFT_SIZE, default 8192, packet size in samples; a power of 2.
REQ-002 SHALL have parameter BUS_NUM, default 2, samples per beat; >= 2.
REQ-003 SHALL have derived parameters PKT_LEN = FFT_SIZE/BUS_NUM beats per packet, and CNT_W = $clog2(PKT_LEN).
REQ-004 SHALL have parameter APB_AW, default 4, APB address width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; one clock, all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have ports in_tvalid (in, 1), in_tready (out, 1) and in_tdata (in, sample_t_int[BUS_NUM]): unframed upstream stream, no tlast.
REQ-008 SHALL have ports out_tvalid (out, 1), out_tready (in, 1), out_tlast (out, 1) and out_tdata (out, sample_t_int[BUS_NUM]): framed stream to the window stage.
REQ-009 SHALL have APB ports psel, penable, pwrite (in, 1), paddr (in, APB_AW), pwdata (in, 32) and prdata (out, 32).

Function
REQ-010 SHALL write a register on psel & !penable & pwrite, decoding paddr[3:2]; prdata SHALL be combinational from paddr.
REQ-011 SHALL have CTRL at 0x0: bit0 EN (RW), bit1 SINGLE (RW), bit8 SOFT_RST (write-1 pulse, reads 0).
REQ-012 SHALL have STATUS at 0x4 (RO): [1:0] state (IDLE=0, RUN=1), [31:16] packets sent, wrapping modulo 2^16.
REQ-013 SHALL have BEAT at 0x8 (RO): [CNT_W-1:0] beat index of the next input beat; 0xC SHALL read 0.
REQ-014 SHALL, in IDLE, hold in_tready=0 and move to RUN in the cycle after EN=1 is observed.
REQ-015 SHALL, in RUN, accept input beats whenever the internal buffer has room; the beat counter SHALL increment per accepted input beat and wrap PKT_LEN-1 -> 0.
REQ-016 SHALL tag the accepted input beat whose counter = PKT_LEN-1 with tlast and carry the tag alongside its data.
REQ-017 SHALL, on acceptance of a tlast beat: go to IDLE and clear EN if SINGLE=1; go to IDLE if EN=0; stay in RUN otherwise.
REQ-018 SHALL, when EN is cleared mid-packet, complete the current packet before leaving RUN; no partial packets are ever emitted.
REQ-019 SHALL buffer through a 2-entry skid buffer: in_tready registered; 1-cycle latency from input accept to out_tvalid; 1 beat/cycle sustained when out_tready=1.
REQ-020 SHALL increment the packet counter on out_tvalid & out_tready & out_tlast.
REQ-021 SHALL hold out_tdata/out_tlast stable while out_tvalid & !out_tready.
REQ-022 SHALL, on SOFT_RST: state->IDLE, EN and SINGLE->0, beat and packet counters->0, skid buffer flushed (out_tvalid->0) on the next cycle; SOFT_RST SHALL win over a simultaneous EN write.
REQ-023 SHALL keep data from beats already in the buffer when entering IDLE until it drains; in_tready SHALL stay 0.

Reset
REQ-024 SHALL, on rst_n=0, set: state IDLE, in_tready=0, out_tvalid=0, out_tlast=0, out_tdata=0, all registers and counters 0.
REQ-025 SHALL apply reset asynchronously on assertion and treat deassertion as synchronous to clk; reset mid-packet SHALL discard the packet.

Structure
REQ-026 SHALL take sample_t_int from axis_pkg and place the framer register offsets (CTRL/STATUS/BEAT) in axis_pkg; the state enum SHALL stay local.
REQ-027 SHALL implement the 2-entry buffer as sub-module axis_skid_buf (parameterised payload width, valid/ready both sides).

Verification (FFT_SIZE=16, BUS_NUM=2, PKT_LEN=8)
REQ-028 SHALL verify: write CTRL=0x1, continuous input, out_tready=1 -> out_tlast on every 8th output beat, first output one cycle after first accept, STATUS[31:16]=3 after 24 beats.
REQ-029 SHALL verify: CTRL=0x3 (SINGLE) -> exactly 8 beats out, state IDLE, CTRL reads 0x2, in_tready=0 afterwards.
REQ-030 SHALL verify: write CTRL=0x0 at beat 3 -> beats 3..7 still accepted, tlast on beat 7, then IDLE; BEAT reads 0.
REQ-031 SHALL verify: random out_tready (50%) and random in_tvalid -> no beat lost or duplicated, data order preserved, tlast every 8 beats, out_tdata stable during stall.
REQ-032 SHALL verify: SOFT_RST (write 0x100) at beat 5 with out_tready=0 -> out_tvalid=0 next cycle, STATUS=0, BEAT=0; re-enable starts a fresh packet at index 0.
REQ-033 SHALL verify: rst_n pulse mid-packet -> all outputs 0 asynchronously; after release plus EN=1, first tlast is at the 8th beat.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types and register map for the AXI-Stream framing path.
package axis_pkg;

    // One complex-free sample as carried on the stream buses.
    typedef logic signed [15:0] sample_t_int;

    localparam int SAMPLE_W = $bits(sample_t_int);

    // Framer register byte offsets on the APB port.
    localparam logic [7:0] FRM_CTRL_OFS   = 8'h00;
    localparam logic [7:0] FRM_STATUS_OFS = 8'h04;
    localparam logic [7:0] FRM_BEAT_OFS   = 8'h08;

    // Word index of a byte offset, as decoded from paddr[3:2].
    function automatic logic [1:0] frm_word_idx(input logic [7:0] ofs);
        return ofs[3:2];
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry buffer with a registered upstream ready, one-cycle latency
// and full throughput when the downstream side is always ready.
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic         push;
    logic         pop;

    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign m_valid = (count != 2'd0);
    assign m_data  = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; drives the registered ready.
    always_comb begin
        count_nxt = count + {1'b0, push} - {1'b0, pop};
    end

    // Storage, pointers and ready; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            s_ready <= 1'b1;
        end else if (flush) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            s_ready <= 1'b1;
        end else begin
            count   <= count_nxt;
            s_ready <= (count_nxt != 2'd2);
            if (push) begin
                mem[wr_ptr] <= s_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end

endmodule

// File: rtl/axis_framer.sv
// Cuts an unframed sample stream into packets of PKT_LEN beats with tlast,
// under APB control (enable, single-packet mode, soft reset).
//
// state | meaning
// IDLE  | input blocked; buffered beats may still drain
// RUN   | accepting beats; leaves only after a tlast beat is accepted
module axis_framer
    import axis_pkg::*;
#(
    parameter  int FFT_SIZE = 8192,
    parameter  int BUS_NUM  = 2,
    parameter  int APB_AW   = 4,
    localparam int PKT_LEN  = FFT_SIZE / BUS_NUM,
    localparam int CNT_W    = $clog2(PKT_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_tvalid,
    output logic              in_tready,
    input  sample_t_int       in_tdata [BUS_NUM],
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic              out_tlast,
    output sample_t_int       out_tdata [BUS_NUM],
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [APB_AW-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;

    localparam int               PAY_W    = BUS_NUM * SAMPLE_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);
    localparam logic [1:0]       IDX_CTRL   = frm_word_idx(FRM_CTRL_OFS);
    localparam logic [1:0]       IDX_STATUS = frm_word_idx(FRM_STATUS_OFS);
    localparam logic [1:0]       IDX_BEAT   = frm_word_idx(FRM_BEAT_OFS);

    logic [1:0]       state;
    logic             en;
    logic             single;
    logic [CNT_W-1:0] beat_cnt;
    logic [15:0]      pkt_cnt;
    logic             wr_ctrl;
    logic             soft_rst;
    logic             buf_ready;
    logic             accept;
    logic             last_beat;
    logic             pkt_done;
    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;
    logic             unused_bits;

    assign wr_ctrl   = psel & ~penable & pwrite & (paddr[3:2] == IDX_CTRL);
    assign soft_rst  = wr_ctrl & pwdata[8];
    assign in_tready = (state == ST_RUN) & buf_ready;
    assign accept    = in_tvalid & in_tready;
    assign last_beat = (beat_cnt == LAST_IDX);
    assign pkt_done  = accept & last_beat;
    assign unused_bits = ^{pwdata, paddr};

    // CTRL bits; single-packet mode drops EN when its packet is fully accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en     <= 1'b0;
            single <= 1'b0;
        end else if (soft_rst) begin
            en     <= 1'b0;
            single <= 1'b0;
        end else begin
            if (pkt_done && single) en <= 1'b0;
            if (wr_ctrl) begin
                en     <= pwdata[0];
                single <= pwdata[1];
            end
        end
    end

    // Framing FSM; only a packet boundary can take RUN back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (soft_rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (en) state <= ST_RUN;
                ST_RUN:  if (pkt_done && (single || !en)) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Beat index within the packet and emitted-packet count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (soft_rst) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            if (out_tvalid && out_tready && out_tlast) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

    // Pack samples plus the tlast tag into one buffer word.
    always_comb begin
        pay_in = '0;
        pay_in[PAY_W-1] = last_beat;
        for (int i = 0; i < BUS_NUM; i++) pay_in[i*SAMPLE_W +: SAMPLE_W] = in_tdata[i];
    end

    axis_skid_buf #(.W(PAY_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (soft_rst),
        .s_valid (in_tvalid & (state == ST_RUN)),
        .s_ready (buf_ready),
        .s_data  (pay_in),
        .m_valid (out_tvalid),
        .m_ready (out_tready),
        .m_data  (pay_out)
    );

    // Unpack the buffer head onto the output bus.
    always_comb begin
        out_tlast = pay_out[PAY_W-1];
        for (int i = 0; i < BUS_NUM; i++) out_tdata[i] = pay_out[i*SAMPLE_W +: SAMPLE_W];
    end

    // Register readback, combinational from the address.
    always_comb begin
        prdata = 32'd0;
        case (paddr[3:2])
            IDX_CTRL:   prdata = {30'd0, single, en};
            IDX_STATUS: prdata = {pkt_cnt, 14'd0, state};
            IDX_BEAT:   prdata = 32'(beat_cnt);
            default:    prdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_axis_framer.sv
// Directed bench for axis_framer with FFT_SIZE=16, BUS_NUM=2 (8-beat packets).
module tb_axis_framer;
    import axis_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_tvalid, in_tready;
    sample_t_int in_tdata [2];
    logic        out_tvalid, out_tready, out_tlast;
    sample_t_int out_tdata [2];
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata, prdata;

    int checks = 0;
    int errors = 0;
    int seq = 0;
    int cyc = 0;
    int acc_q[$];
    int acc_cyc[$];
    int out_cyc[$];
    logic [15:0] out_d0[$];
    logic [15:0] out_d1[$];
    bit          out_last[$];
    bit          stall;
    logic [15:0] st_d0, st_d1;
    logic        st_last;
    logic [31:0] r_ctrl, r_status, r_beat;

    always #5 clk = ~clk;

    axis_framer #(.FFT_SIZE(16), .BUS_NUM(2), .APB_AW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .out_tdata(out_tdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata)
    );

    // Called at a negedge: drive, log the handshakes of the coming posedge.
    task automatic cycle(input bit vld, input bit rdy);
        logic [15:0] s;
        s = seq[15:0];
        in_tvalid   = vld;
        out_tready  = rdy;
        in_tdata[0] = sample_t_int'(s);
        in_tdata[1] = sample_t_int'(s ^ 16'hA5A5);
        #1;
        if (out_tvalid && out_tready) begin
            out_d0.push_back(out_tdata[0]);
            out_d1.push_back(out_tdata[1]);
            out_last.push_back(out_tlast);
            out_cyc.push_back(cyc);
        end
        if (in_tvalid && in_tready) begin
            acc_q.push_back(seq);
            acc_cyc.push_back(cyc);
            seq++;
        end
        stall   = out_tvalid && !out_tready;
        st_d0   = out_tdata[0];
        st_d1   = out_tdata[1];
        st_last = out_tlast;
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_logs();
        acc_q.delete(); acc_cyc.delete(); out_cyc.delete();
        out_d0.delete(); out_d1.delete(); out_last.delete();
        stall = 0;
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d, input bit vld, input bit rdy);
        psel = 1; pwrite = 1; penable = 0; paddr = a; pwdata = d;
        cycle(vld, rdy);
        penable = 1;
        cycle(vld, rdy);
        psel = 0; penable = 0; pwrite = 0;
    endtask

    // Read CTRL/STATUS/BEAT with input idle, then realign to a negedge.
    task automatic read_regs();
        in_tvalid = 0;
        paddr = 4'h0; #1; r_ctrl = prdata;
        paddr = 4'h4; #1; r_status = prdata;
        paddr = 4'h8; #1; r_beat = prdata;
        paddr = 4'hC; #1;
        checks++;
        if (prdata !== 32'd0) begin errors++; $display("FAIL reg_0xC got %h want 0", prdata); end
        @(negedge clk);
        cyc++;
    endtask

    task automatic soft_reset();
        apb_write(4'h0, 32'h100, 0, 1);
    endtask

    task automatic test_reset();
        checks++;
        if ({in_tready, out_tvalid, out_tlast} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl got %b want 000", {in_tready, out_tvalid, out_tlast});
        end
        checks++;
        if ({out_tdata[0], out_tdata[1]} !== 32'd0) begin
            errors++; $display("FAIL reset_data got %h want 0", {out_tdata[0], out_tdata[1]});
        end
        rst_n = 1;
        read_regs();
        checks++;
        if ({r_ctrl, r_status, r_beat} !== 96'd0) begin
            errors++; $display("FAIL reset_regs got %h %h %h want 0", r_ctrl, r_status, r_beat);
        end
    endtask

    task automatic test_continuous();
        clear_logs();
        apb_write(4'h0, 32'h1, 1, 1);
        for (int i = 0; i < 80 && acc_q.size() < 24; i++) cycle(1, 1);
        repeat (4) cycle(0, 1);
        checks++;
        if (acc_q.size() != 24 || out_d0.size() != 24) begin
            errors++; $display("FAIL cont_count got acc %0d out %0d want 24", acc_q.size(), out_d0.size());
        end else begin
            checks++;
            if (out_cyc[0] != acc_cyc[0] + 1) begin
                errors++; $display("FAIL cont_latency got %0d want %0d", out_cyc[0], acc_cyc[0] + 1);
            end
            checks++;
            if (acc_cyc[23] - acc_cyc[0] != 23) begin
                errors++; $display("FAIL cont_rate got span %0d want 23", acc_cyc[23] - acc_cyc[0]);
            end
            for (int i = 0; i < 24; i++) begin
                checks++;
                if (out_last[i] !== (i % 8 == 7)) begin
                    errors++; $display("FAIL cont_tlast beat %0d got %b want %b", i, out_last[i], (i % 8 == 7));
                end
                checks++;
                if (out_d0[i] !== acc_q[i][15:0] || out_d1[i] !== (acc_q[i][15:0] ^ 16'hA5A5)) begin
                    errors++; $display("FAIL cont_data beat %0d got %h/%h want seq %0d", i, out_d0[i], out_d1[i], acc_q[i]);
                end
            end
        end
        read_regs();
        checks++;
        if (r_status[31:16] !== 16'd3) begin
            errors++; $display("FAIL cont_pkts got %0d want 3", r_status[31:16]);
        end
        checks++;
        if (r_status[1:0] !== 2'd1) begin
            errors++; $display("FAIL cont_state got %0d want 1", r_status[1:0]);
        end
        soft_reset();
    endtask

    task automatic test_single();
        clear_logs();
        apb_write(4'h0, 32'h3, 1, 1);
        repeat (30) cycle(1, 1);
        checks++;
        if (acc_q.size() != 8 || out_d0.size() != 8) begin
            errors++; $display("FAIL single_count got acc %0d out %0d want 8", acc_q.size(), out_d0.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (out_last[i] !== (i == 7)) begin
                    errors++; $display("FAIL single_tlast beat %0d got %b want %b", i, out_last[i], (i == 7));
                end
            end
        end
        checks++;
        if (in_tready !== 1'b0) begin errors++; $display("FAIL single_ready got %b want 0", in_tready); end
        read_regs();
        checks++;
        if (r_ctrl !== 32'h2) begin errors++; $display("FAIL single_ctrl got %h want 2", r_ctrl); end
        checks++;
        if (r_status !== 32'h0001_0000) begin errors++; $display("FAIL single_status got %h want 00010000", r_status); end
        soft_reset();
    endtask

    task automatic test_disable_mid();
        clear_logs();
        apb_write(4'h0, 32'h1, 0, 1);
        for (int i = 0; i < 40 && acc_q.size() < 3; i++) cycle(1, 1);
        apb_write(4'h0, 32'h0, 1, 1);
        repeat (20) cycle(1, 1);
        checks++;
        if (acc_q.size() != 8 || out_d0.size() != 8) begin
            errors++; $display("FAIL dis_count got acc %0d out %0d want 8", acc_q.size(), out_d0.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (out_last[i] !== (i == 7)) begin
                    errors++; $display("FAIL dis_tlast beat %0d got %b want %b", i, out_last[i], (i == 7));
                end
            end
        end
        checks++;
        if (in_tready !== 1'b0) begin errors++; $display("FAIL dis_ready got %b want 0", in_tready); end
        read_regs();
        checks++;
        if (r_beat !== 32'd0 || r_status[1:0] !== 2'd0 || r_ctrl !== 32'd0) begin
            errors++; $display("FAIL dis_regs got beat %h status %h ctrl %h want 0/state0/0", r_beat, r_status, r_ctrl);
        end
        soft_reset();
    endtask

    task automatic test_random();
        clear_logs();
        apb_write(4'h0, 32'h1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            if (stall) begin
                checks++;
                if (out_tvalid !== 1'b1 || out_tdata[0] !== st_d0 || out_tdata[1] !== st_d1 || out_tlast !== st_last) begin
                    errors++; $display("FAIL rand_stall cyc %0d got v%b %h/%h l%b want v1 %h/%h l%b",
                        cyc, out_tvalid, out_tdata[0], out_tdata[1], out_tlast, st_d0, st_d1, st_last);
                end
            end
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (6) cycle(0, 1);
        checks++;
        if (acc_q.size() < 16 || out_d0.size() != acc_q.size()) begin
            errors++; $display("FAIL rand_count got acc %0d out %0d want equal and >=16", acc_q.size(), out_d0.size());
        end else begin
            for (int i = 0; i < out_d0.size(); i++) begin
                checks++;
                if (out_d0[i] !== acc_q[i][15:0] || out_d1[i] !== (acc_q[i][15:0] ^ 16'hA5A5) || out_last[i] !== (i % 8 == 7)) begin
                    errors++; $display("FAIL rand_beat %0d got %h/%h l%b want seq %0d l%b",
                        i, out_d0[i], out_d1[i], out_last[i], acc_q[i], (i % 8 == 7));
                end
            end
        end
        soft_reset();
    endtask

    task automatic test_soft_reset();
        clear_logs();
        apb_write(4'h0, 32'h1, 0, 1);
        for (int i = 0; i < 40 && acc_q.size() < 5; i++) cycle(1, 1);
        psel = 1; pwrite = 1; penable = 0; paddr = 4'h0; pwdata = 32'h100;
        cycle(0, 0);
        psel = 0; pwrite = 0;
        checks++;
        if (out_tvalid !== 1'b0 || in_tready !== 1'b0) begin
            errors++; $display("FAIL srst_flush got valid %b ready %b want 0 0", out_tvalid, in_tready);
        end
        read_regs();
        checks++;
        if (r_status !== 32'd0 || r_beat !== 32'd0 || r_ctrl !== 32'd0) begin
            errors++; $display("FAIL srst_regs got status %h beat %h ctrl %h want 0", r_status, r_beat, r_ctrl);
        end
        clear_logs();
        apb_write(4'h0, 32'h1, 0, 1);
        for (int i = 0; i < 40 && acc_q.size() < 8; i++) cycle(1, 1);
        repeat (4) cycle(0, 1);
        checks++;
        if (out_d0.size() != 8) begin
            errors++; $display("FAIL srst_count got %0d want 8", out_d0.size());
        end else begin
            checks++;
            if (out_d0[0] !== acc_q[0][15:0]) begin
                errors++; $display("FAIL srst_first got %h want %h", out_d0[0], acc_q[0][15:0]);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (out_last[i] !== (i == 7)) begin
                    errors++; $display("FAIL srst_tlast beat %0d got %b want %b", i, out_last[i], (i == 7));
                end
            end
        end
        soft_reset();
    endtask

    task automatic test_async_reset();
        clear_logs();
        apb_write(4'h0, 32'h1, 0, 1);
        for (int i = 0; i < 40 && acc_q.size() < 4; i++) cycle(1, 1);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({in_tready, out_tvalid, out_tlast, out_tdata[0], out_tdata[1]} !== 35'd0) begin
            errors++; $display("FAIL arst_out got rdy %b v %b l %b d %h/%h want all 0",
                in_tready, out_tvalid, out_tlast, out_tdata[0], out_tdata[1]);
        end
        in_tvalid = 0;
        @(negedge clk);
        cyc++;
        rst_n = 1;
        read_regs();
        checks++;
        if ({r_ctrl, r_status, r_beat} !== 96'd0) begin
            errors++; $display("FAIL arst_regs got %h %h %h want 0", r_ctrl, r_status, r_beat);
        end
        clear_logs();
        apb_write(4'h0, 32'h1, 0, 1);
        for (int i = 0; i < 40 && acc_q.size() < 8; i++) cycle(1, 1);
        repeat (4) cycle(0, 1);
        checks++;
        if (out_d0.size() != 8) begin
            errors++; $display("FAIL arst_count got %0d want 8", out_d0.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (out_last[i] !== (i == 7) || out_d0[i] !== acc_q[i][15:0]) begin
                    errors++; $display("FAIL arst_beat %0d got %h l%b want %h l%b",
                        i, out_d0[i], out_last[i], acc_q[i][15:0], (i == 7));
                end
            end
        end
    endtask

    initial begin
        rst_n = 0; in_tvalid = 0; out_tready = 0;
        in_tdata[0] = '0; in_tdata[1] = '0;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        stall = 0;
        repeat (3) @(negedge clk);
        test_reset();
        test_continuous();
        test_single();
        test_disable_mid();
        test_random();
        test_soft_reset();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
